// File: rtl/interrupt_requester_if.sv
// Handshake bundle between interrupt_requester (master) and the interrupt controller (slave).
// ovf_o exists only when INTREQ_OVF_STAT_EN is defined.
interface interrupt_requester_if #(
    parameter int N_SRC = 32
) ();
    logic [N_SRC-1:0] int_req_o;
    logic [N_SRC-1:0] int_fin_i;
    logic [N_SRC-1:0] pending_o;
`ifdef INTREQ_OVF_STAT_EN
    logic [N_SRC-1:0] ovf_o;
`endif

    // Requester drives int_req_o/pending_o; the controller answers each request with a
    // one-cycle int_fin_i pulse while int_req_o is high. A fin seen at any other time is ignored.
`ifdef INTREQ_OVF_STAT_EN
    modport master (output int_req_o, output pending_o, output ovf_o, input int_fin_i);
    modport slave  (input int_req_o, input pending_o, input ovf_o, output int_fin_i);
`else
    modport master (output int_req_o, output pending_o, input int_fin_i);
    modport slave  (input int_req_o, input pending_o, output int_fin_i);
`endif
endinterface

// File: rtl/interrupt_requester.sv
// Per-line interrupt requester: counts event rising edges and requests them one at a time.
// Optional sticky overflow flags are built when INTREQ_OVF_STAT_EN is defined.
module interrupt_requester #(
    parameter int N_SRC   = 32,
    parameter int CNT_W   = 2,
    parameter int HOLDOFF = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_SRC-1:0]       event_i,
    input  logic [N_SRC-1:0]       en_i,
    input  logic [N_SRC-1:0]       clr_i,
    interrupt_requester_if.master  irq,
    output logic [2*N_SRC-1:0]     state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       HOLD_LOAD = 4'(HOLDOFF - 1);

    state_t           state_q [N_SRC];
    state_t           state_d [N_SRC];
    logic [CNT_W-1:0] cnt_q   [N_SRC];
    logic [CNT_W-1:0] cnt_d   [N_SRC];
    logic [3:0]       hold_q  [N_SRC];
    logic [3:0]       hold_d  [N_SRC];
    logic [N_SRC-1:0] event_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] fin_acc;
    logic [N_SRC-1:0] drop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            event_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            event_q <= event_i;
            for (int i = 0; i < N_SRC; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    always_comb begin
        rise    = '0;
        fin_acc = '0;
        drop    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hold_d[i]  = hold_q[i];

            rise[i]    = event_i[i] & ~event_q[i] & en_i[i];
            fin_acc[i] = irq.int_fin_i[i] & (state_q[i] == REQ);
            // A rise paired with a finish nets to zero, so it is never counted as dropped.
            drop[i]    = rise[i] & (cnt_q[i] == CNT_MAX) & ~fin_acc[i];

            if (rise[i] && !fin_acc[i] && cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (fin_acc[i] && !rise[i])
                cnt_d[i] = cnt_q[i] - 1'b1;

            unique case (state_q[i])
                IDLE: begin
                    if (cnt_d[i] != '0)
                        state_d[i] = REQ;
                end
                REQ: begin
                    if (fin_acc[i]) begin
                        state_d[i] = HOLD;
                        hold_d[i]  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_q[i] == '0)
                        state_d[i] = (cnt_d[i] != '0) ? REQ : IDLE;
                    else
                        hold_d[i] = hold_q[i] - 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase

            if (clr_i[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                hold_d[i]  = '0;
            end
        end
    end

    always_comb begin
        irq.int_req_o = '0;
        irq.pending_o = '0;
        state_dbg_o   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            irq.int_req_o[i]         = (state_q[i] == REQ);
            irq.pending_o[i]         = (cnt_q[i] != '0);
            state_dbg_o[2*i +: 2]    = state_q[i];
        end
    end

`ifdef INTREQ_OVF_STAT_EN
    logic [N_SRC-1:0] ovf_q;

    // Clear wins over a same-cycle overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            ovf_q <= '0;
        else
            ovf_q <= (ovf_q | drop) & ~clr_i;
    end

    assign irq.ovf_o = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_interrupt_requester.sv
// Directed bench for interrupt_requester with N_SRC=4, CNT_W=2, HOLDOFF=2.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_interrupt_requester;

    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic [N-1:0]   event_i = '0;
    logic [N-1:0]   en_i = '1;
    logic [N-1:0]   clr_i = '0;
    logic [2*N-1:0] state_dbg_o;

    int n_checks = 0;
    int n_errors = 0;

    interrupt_requester_if #(.N_SRC(N)) irq ();

    interrupt_requester #(.N_SRC(N), .CNT_W(2), .HOLDOFF(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .event_i     (event_i),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .irq         (irq),
        .state_dbg_o (state_dbg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        irq.int_fin_i = '0;

        // reset
        #2;
        check("rst_req", 32'(irq.int_req_o), 32'h0);
        check("rst_pend", 32'(irq.pending_o), 32'h0);
        check("rst_state", 32'(state_dbg_o), 32'h0);
        tick();
        rst_i = 1'b1;
        tick();

        // 1: single request on line 1
        event_i = 4'b0010;
        tick();
        check("t1_req", 32'(irq.int_req_o), 32'h2);
        check("t1_pend", 32'(irq.pending_o), 32'h2);
        event_i = '0;
        tick();
        tick();
        tick();
        check("t1_req_hold", 32'(irq.int_req_o), 32'h2);
        irq.int_fin_i = 4'b0010;
        tick();
        irq.int_fin_i = '0;
        check("t1_req_drop", 32'(irq.int_req_o), 32'h0);
        check("t1_pend_drop", 32'(irq.pending_o), 32'h0);
        tick();
        tick();
        check("t1_idle", 32'(irq.int_req_o), 32'h0);

        // 2: saturate line 0, fourth rise dropped, three requests
        for (int k = 0; k < 4; k++) begin
            event_i = 4'b0001;
            tick();
            event_i = '0;
            tick();
        end
        check("t2_req", 32'(irq.int_req_o), 32'h1);
        check("t2_pend", 32'(irq.pending_o), 32'h1);
`ifdef INTREQ_OVF_STAT_EN
        check("t2_ovf", 32'(irq.ovf_o), 32'h1);
`endif
        for (int k = 0; k < 3; k++) begin
            irq.int_fin_i = 4'b0001;
            tick();
            irq.int_fin_i = '0;
            check("t2_gap0", 32'(irq.int_req_o), 32'h0);
            tick();
            check("t2_gap1", 32'(irq.int_req_o), 32'h0);
            tick();
            check("t2_rereq", 32'(irq.int_req_o), (k < 2) ? 32'h1 : 32'h0);
        end
        check("t2_pend_end", 32'(irq.pending_o), 32'h0);

        // 3: rise and fin together on line 2 with cnt=1
        event_i = 4'b0100;
        tick();
        event_i = '0;
        tick();
        check("t3_req", 32'(irq.int_req_o), 32'h4);
        event_i = 4'b0100;
        irq.int_fin_i = 4'b0100;
        tick();
        event_i = '0;
        irq.int_fin_i = '0;
        check("t3_hold_req", 32'(irq.int_req_o), 32'h0);
        check("t3_hold_pend", 32'(irq.pending_o), 32'h4);
        tick();
        check("t3_hold2", 32'(irq.int_req_o), 32'h0);
        tick();
        check("t3_rereq", 32'(irq.int_req_o), 32'h4);
        irq.int_fin_i = 4'b0100;
        tick();
        irq.int_fin_i = '0;
        tick();
        tick();
        check("t3_done", 32'(irq.pending_o), 32'h0);

        // 4: fin on line 3 while IDLE and while in HOLD is ignored
        irq.int_fin_i = 4'b1000;
        tick();
        irq.int_fin_i = '0;
        check("t4_idle_req", 32'(irq.int_req_o), 32'h0);
        check("t4_idle_pend", 32'(irq.pending_o), 32'h0);
        check("t4_idle_state", 32'(state_dbg_o[7:6]), 32'h0);
        event_i = 4'b1000;
        tick();
        event_i = '0;
        tick();
        event_i = 4'b1000;
        tick();
        event_i = '0;
        irq.int_fin_i = 4'b1000;
        tick();
        check("t4_hold_state", 32'(state_dbg_o[7:6]), 32'h2);
        tick();
        irq.int_fin_i = '0;
        check("t4_hold_pend", 32'(irq.pending_o), 32'h8);
        tick();
        check("t4_rereq", 32'(irq.int_req_o), 32'h8);
        irq.int_fin_i = 4'b1000;
        tick();
        tick();
        irq.int_fin_i = '0;
        tick();
        check("t4_end_req", 32'(irq.int_req_o), 32'h0);
        check("t4_end_state", 32'(state_dbg_o[7:6]), 32'h0);

        // 5: clear on line 0 in REQ with cnt=2 plus a rise and fin
        event_i = 4'b0001;
        tick();
        event_i = '0;
        tick();
        event_i = 4'b0001;
        tick();
        event_i = '0;
        tick();
        check("t5_pre_req", 32'(irq.int_req_o), 32'h1);
        clr_i = 4'b0001;
        event_i = 4'b0001;
        irq.int_fin_i = 4'b0001;
        tick();
        clr_i = '0;
        event_i = '0;
        irq.int_fin_i = '0;
        check("t5_clr_req", 32'(irq.int_req_o), 32'h0);
        check("t5_clr_pend", 32'(irq.pending_o), 32'h0);
`ifdef INTREQ_OVF_STAT_EN
        check("t5_clr_ovf", 32'(irq.ovf_o), 32'h0);
`endif
        tick();
        tick();
        tick();
        check("t5_no_reraise", 32'(irq.int_req_o), 32'h0);

        // 6a: disabled line ignores events
        en_i = 4'b1101;
        for (int k = 0; k < 2; k++) begin
            event_i = 4'b0010;
            tick();
            event_i = '0;
            tick();
        end
        check("t6_dis_req", 32'(irq.int_req_o), 32'h0);
        check("t6_dis_pend", 32'(irq.pending_o), 32'h0);
        en_i = '1;

        // 6b: event held high through reset release gives exactly one request
        event_i = 4'b0010;
        #3 rst_i = 1'b0;
        #2 rst_i = 1'b1;
        tick();
        check("t6_rst_req", 32'(irq.int_req_o), 32'h2);
        tick();
        tick();
        check("t6_rst_pend", 32'(irq.pending_o), 32'h2);
        irq.int_fin_i = 4'b0010;
        tick();
        irq.int_fin_i = '0;
        tick();
        tick();
        tick();
        check("t6_one_req", 32'(irq.int_req_o), 32'h0);
        check("t6_one_pend", 32'(irq.pending_o), 32'h0);
        event_i = '0;

        // 6c: asynchronous reset mid-request
        event_i = 4'b0100;
        tick();
        check("t6_mid_req", 32'(irq.int_req_o), 32'h4);
        event_i = '0;
        #2 rst_i = 1'b0;
        #1;
        check("t6_async_req", 32'(irq.int_req_o), 32'h0);
        check("t6_async_pend", 32'(irq.pending_o), 32'h0);
        #2 rst_i = 1'b1;
        tick();
        check("t6_after_rst", 32'(irq.int_req_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
